// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter. It inhibits the bus, requests to send,
// and shifts out an 11-bit frame on device clock falls, then checks the ACK. Lines are driven only through open-drain enables.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 1500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);
    localparam int unsigned CNT_MAX  = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CW       = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    clk_sync_q, data_sync_q;
    logic          clk_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [8:0]    shift_q, shift_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic          data_oe_q, data_oe_d;
    logic          nak_q, nak_d;
    logic          done_q, done_d;
    logic          ack_err_q, ack_err_d;
    logic          to_err_q, to_err_d;

    logic sync_clk, sync_data, fall, timed, bus_idle;

    assign sync_clk  = clk_sync_q[1];
    assign sync_data = data_sync_q[1];
    assign fall      = clk_prev_q & ~sync_clk;
    assign bus_idle  = sync_clk & sync_data;
    assign timed     = (state_q == REQ) || (state_q == SEND) || (state_q == ACK) || (state_q == WAIT_IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        data_oe_d = data_oe_q;
        nak_d     = nak_q;
        done_d    = 1'b0;
        ack_err_d = 1'b0;
        to_err_d  = 1'b0;

        if (timed) begin
            cnt_d = fall ? '0 : cnt_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    shift_d   = {~^tx_data, tx_data};
                    bit_cnt_d = '0;
                    cnt_d     = '0;
                    nak_d     = 1'b0;
                    data_oe_d = 1'b0;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                // Device clock falls here are our own inhibit pulling the line, so they are ignored
                if (cnt_q == INH_LAST) begin
                    data_oe_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = REQ;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            REQ: begin
                cnt_d     = '0;
                bit_cnt_d = '0;
                state_d   = SEND;
            end
            SEND: begin
                if (fall) begin
                    if (bit_cnt_q < 4'd9) begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = {1'b0, shift_q[8:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else begin
                        data_oe_d = 1'b0;
                        state_d   = ACK;
                    end
                end
            end
            ACK: begin
                if (fall) begin
                    nak_d   = sync_data;
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (bus_idle) begin
                    done_d    = 1'b1;
                    ack_err_d = nak_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A fall in the terminal cycle has already cleared the counter, so the fall wins.
        if (timed && !fall && cnt_q == TO_LAST && !(state_q == WAIT_IDLE && bus_idle)) begin
            data_oe_d = 1'b0;
            done_d    = 1'b1;
            ack_err_d = 1'b0;
            to_err_d  = 1'b1;
            state_d   = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
            cnt_q       <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            data_oe_q   <= 1'b0;
            nak_q       <= 1'b0;
            done_q      <= 1'b0;
            ack_err_q   <= 1'b0;
            to_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
            clk_prev_q  <= sync_clk;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            data_oe_q   <= data_oe_d;
            nak_q       <= nak_d;
            done_q      <= done_d;
            ack_err_q   <= ack_err_d;
            to_err_q    <= to_err_d;
        end
    end

    // The enables decode from reset-cleared state, so an async reset releases both lines at once.
    assign ps2_clk_oe  = (state_q == INHIBIT);
    assign ps2_data_oe = data_oe_q | ((state_q == INHIBIT) && (cnt_q == INH_LAST));
    assign busy        = (state_q != IDLE);
    assign tx_ready    = (state_q == IDLE);
    assign done        = done_q;
    assign ack_err     = ack_err_q;
    assign timeout_err = to_err_q;
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, for example 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset).
- Shares the PS2_CLK/PS2_DATA pins with the keyboard receive path. It drives the lines only through open-drain enables; the top level does `pin = oe ? 1'b0 : 1'bz`.
- Frame sent: inhibit, start bit, 8 data bits LSB first, odd parity, stop bit, then the device ACK is sampled.

Parameters:
- INHIBIT_CYCLES, 10000: clk cycles the host holds PS2_CLK low before the request (100 us at 100 MHz).
- TIMEOUT_CYCLES, 1500000: maximum clk cycles allowed between device clock falling edges, and for bus-idle wait (15 ms).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- tx_data  in  8  command byte.
- tx_valid  in  1  request; accepted when tx_valid && tx_ready.
- tx_ready  out  1  high only in IDLE.
- ps2_clk_in  in  1  PS2_CLK pin level.
- ps2_data_in  in  1  PS2_DATA pin level.
- ps2_clk_oe  out  1  1 = pull PS2_CLK low.
- ps2_data_oe  out  1  1 = pull PS2_DATA low.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a frame ends: ACK completed or timeout.
- ack_err  out  1  one-cycle pulse with done when ACK sampled high.
- timeout_err  out  1  one-cycle pulse with done on timeout.

Behaviour:
- Reset (rst=0, async):
  - State IDLE; ps2_clk_oe=0, ps2_data_oe=0; done, ack_err, timeout_err = 0; busy=0; tx_ready=1.
  - Synchronizers preset to 1; counters and shift register cleared.
  - Reset mid-frame releases both lines immediately (asynchronously).
- Input sync: ps2_clk_in and ps2_data_in each pass through a 2-FF synchronizer.
  - fall = (prev_sync_clk==1 && sync_clk==0), evaluated one cycle after the sync stage.
- Accept: in IDLE with tx_valid=1, latch {parity, tx_data} into a 9-bit shift register, where parity = ~^tx_data (odd parity). Next state is INHIBIT.
  - tx_valid while busy is ignored. There is no queue.
- INHIBIT: ps2_clk_oe=1, ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles.
  - In the last cycle set ps2_data_oe=1 (start bit 0), then go to REQ.
- REQ: ps2_clk_oe=0, ps2_data_oe=1. Reset the timeout counter, then go to SEND with bit_cnt=0.
- SEND: on each fall, by the next clk edge:
  - bit_cnt 0..8: ps2_data_oe = ~shift[0]; shift right by one; bit_cnt++.
  - bit_cnt 9 (stop bit): ps2_data_oe=0; go to ACK.
  - Data changes only right after a fall, so it is stable while the device clock is low and before the rising edge.
- ACK: on the next fall, sample sync_data.
  - Sampled 0 = ACK.
  - Sampled 1 = NAK; record ack_err.
  - Go to WAIT_IDLE.
- WAIT_IDLE: wait for sync_clk==1 && sync_data==1. Then pulse done (plus ack_err if NAK recorded) and return to IDLE.
- Timeout:
  - The counter resets on every fall and on every state entry, and runs in REQ, SEND, ACK and WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES causes: both oe=0, done=1 and timeout_err=1 for one cycle, then IDLE.
- Simultaneous events: a fall on the same cycle as the timeout terminal count means the fall wins and the counter resets.
- Pulse timing: done, ack_err and timeout_err are registered and coincide with the cycle tx_ready returns to 1.
- No data change at wrap-around: bit_cnt is 4 bits and saturates in ACK/WAIT_IDLE.
- Glitch tolerance: a fall occurring while in INHIBIT (host-driven clock) is ignored.

Test Plan:
1. INHIBIT_CYCLES=100, tx_data=0xED, with a device model generating a 10 kHz clock (scaled) and ACK 0.
   - Required: ps2_clk_oe high exactly 100 cycles.
   - Required: bits after falls 1–10 read 1,0,1,1,0,1,1,1, parity=1, stop=1 (oe=0).
   - Required: ACK sampled 0, done=1, ack_err=0, tx_ready=1.
2. tx_data=0x01 then 0xFF, back-to-back.
   - Required: parity 0 for 0x01 and 1 for 0xFF.
   - Required: the second request is accepted only after done of the first.
   - Required: tx_valid pulsed during busy is dropped (exactly 2 frames seen).
3. Device holds data high in the ACK slot.
   - Required: done=1 with ack_err=1 in the same cycle; timeout_err=0.
4. TIMEOUT_CYCLES=500; the device stops clocking after the 4th fall.
   - Required: exactly 500 cycles after the last fall, both oe=0, done=timeout_err=1 for one cycle, then IDLE.
5. Assert rst=0 mid-SEND (bit_cnt=5).
   - Required: ps2_clk_oe=ps2_data_oe=0 in the same cycle (async).
   - Required: busy=0 and tx_ready=1 after release; a new 0xF4 frame completes correctly.
6. After the ACK, the device holds clk low 20 cycles.
   - Required: done is asserted only on the first cycle after both synced lines read 1.
